// File: rtl/fp_sign_unit.sv
// Sign/magnitude front end for FPU add/sub: result sign, effective op, swap and special flags.
// Latency 2 cycles (S1 compare/classify, S2 decide); full throughput; valid/ready stalls hold S2.
// Backpressure propagates stage by stage; FP_SIGN_SPECIALS_EN enables Inf/NaN handling.
module fp_sign_unit #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int TAG_BITS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_BITS+MANT_BITS:0]   op_a,
    input  logic [EXP_BITS+MANT_BITS:0]   op_b,
    input  logic                          operation_select,
    input  logic                          rm_down,
    input  logic [TAG_BITS-1:0]           in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sign_r,
    output logic                          eff_sub,
    output logic                          swap,
    output logic                          exact_cancel,
    output logic                          inf_r,
    output logic                          nan_r,
    output logic                          invalid,
    output logic [TAG_BITS-1:0]           out_tag
);
    localparam int MW = EXP_BITS + MANT_BITS;

    logic                en1, en2;
    logic                v1;
    logic                s1_sign_a, s1_sign_b_op, s1_rm_down, s1_gt, s1_eq;
    logic [TAG_BITS-1:0] s1_tag;
    logic                sign_b_op;

    assign en2       = !out_valid || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign sign_b_op = operation_select ? op_b[MW] : ~op_b[MW];

`ifdef FP_SIGN_SPECIALS_EN
    logic s1_inf_a, s1_nan_a, s1_inf_b, s1_nan_b;

    function automatic logic exp_max(input logic [MW-1:0] m);
        return &m[MW-1:MANT_BITS];
    endfunction

    function automatic logic mant_nz(input logic [MW-1:0] m);
        return |m[MANT_BITS-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_inf_a <= 1'b0;
            s1_nan_a <= 1'b0;
            s1_inf_b <= 1'b0;
            s1_nan_b <= 1'b0;
        end else if (en1) begin
            s1_inf_a <= exp_max(op_a[MW-1:0]) && !mant_nz(op_a[MW-1:0]);
            s1_nan_a <= exp_max(op_a[MW-1:0]) &&  mant_nz(op_a[MW-1:0]);
            s1_inf_b <= exp_max(op_b[MW-1:0]) && !mant_nz(op_b[MW-1:0]);
            s1_nan_b <= exp_max(op_b[MW-1:0]) &&  mant_nz(op_b[MW-1:0]);
        end
    end
`endif

    // Unsigned compare of {exp,mant} orders IEEE magnitudes; zeros fall out as magnitude 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1           <= 1'b0;
            s1_sign_a    <= 1'b0;
            s1_sign_b_op <= 1'b0;
            s1_rm_down   <= 1'b0;
            s1_gt        <= 1'b0;
            s1_eq        <= 1'b0;
            s1_tag       <= '0;
        end else if (en1) begin
            v1           <= in_valid;
            s1_sign_a    <= op_a[MW];
            s1_sign_b_op <= sign_b_op;
            s1_rm_down   <= rm_down;
            s1_gt        <= op_a[MW-1:0] > op_b[MW-1:0];
            s1_eq        <= op_a[MW-1:0] == op_b[MW-1:0];
            s1_tag       <= in_tag;
        end
    end

    logic n_sign, n_eff_sub, n_swap, n_cancel, n_inf, n_nan, n_invalid;

    always_comb begin
        n_sign    = 1'b0;
        n_swap    = 1'b0;
        n_cancel  = 1'b0;
        n_inf     = 1'b0;
        n_nan     = 1'b0;
        n_invalid = 1'b0;
        n_eff_sub = s1_sign_a ^ s1_sign_b_op;
`ifdef FP_SIGN_SPECIALS_EN
        if (s1_nan_a || s1_nan_b) begin
            n_nan = 1'b1;
        end else if (s1_inf_a && s1_inf_b && n_eff_sub) begin
            n_nan     = 1'b1;
            n_invalid = 1'b1;
        end else if (s1_inf_a) begin
            n_inf  = 1'b1;
            n_sign = s1_sign_a;
        end else if (s1_inf_b) begin
            n_inf  = 1'b1;
            n_sign = s1_sign_b_op;
        end else
`endif
        if (s1_gt) begin
            n_sign = s1_sign_a;
        end else if (!s1_eq) begin
            n_sign = s1_sign_b_op;
            n_swap = 1'b1;
        end else if (!n_eff_sub) begin
            n_sign = s1_sign_a;
        end else begin
            n_cancel = 1'b1;
            n_sign   = s1_rm_down;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            sign_r       <= 1'b0;
            eff_sub      <= 1'b0;
            swap         <= 1'b0;
            exact_cancel <= 1'b0;
            inf_r        <= 1'b0;
            nan_r        <= 1'b0;
            invalid      <= 1'b0;
            out_tag      <= '0;
        end else if (en2) begin
            out_valid    <= v1;
            sign_r       <= n_sign;
            eff_sub      <= n_eff_sub;
            swap         <= n_swap;
            exact_cancel <= n_cancel;
            inf_r        <= n_inf;
            nan_r        <= n_nan;
            invalid      <= n_invalid;
            out_tag      <= s1_tag;
        end
    end
endmodule
